// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
//   Oversampling UART receiver. Finds the start bit on a high->low edge of
//   the serial line, majority-votes three samples around the middle of every
//   bit, shifts data in LSB first, checks an optional parity bit and the stop
//   bit, then reports the frame with one-cycle pulses.
//
// Parameters
//   OVERSAMPLE  CLK cycles per UART bit (even, >= 4)
//   DATA_WIDTH  data bits per frame
//
// Ports
//   CLK         receiver clock, OVERSAMPLE x baud
//   RST         synchronous, active-low reset
//   RX_IN       serial line, idle high
//   PAR_EN      1 = parity bit follows the data bits
//   PAR_TYP     0 = even parity, 1 = odd parity
//   P_DATA      last frame received without error
//   Data_Valid  one-cycle pulse, P_DATA has just been updated
//   par_err     one-cycle pulse, parity bit disagreed with the data
//   stp_err     one-cycle pulse, stop bit was sampled low
//
// Build option
//   RX_INPUT_SYNC_EN : when defined, RX_IN passes a 2-flop synchronizer
//   (reset to 1) before edge detection; every latency grows by 2 cycles.
//   When undefined, RX_IN must already be synchronous to CLK.
// ---------------------------------------------------------------------------
module uart_rx_core #(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int M  = OVERSAMPLE / 2;
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] C_SAMP0  = CW'(M - 1);
  localparam logic [CW-1:0] C_SAMP1  = CW'(M);
  localparam logic [CW-1:0] C_DECIDE = CW'(M + 1);
  localparam logic [CW-1:0] C_WRAP   = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] C_LASTB  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic                  w_rx;
  logic                  r_prev;
  logic [CW-1:0]         r_edge_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic                  r_s0;
  logic                  r_s1;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_bad;
  logic                  r_stop_bit;
  logic                  r_res_pend;

  logic                  w_start_edge;
  logic                  w_wrap;
  logic                  w_decide;
  logic                  w_majority;
  logic                  w_last_bit;
  logic                  w_par_exp;

  // -------------------------------------------------------------------------
  // Line input, optionally resynchronised
  // -------------------------------------------------------------------------
`ifdef RX_INPUT_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RX_IN;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;
`else
  assign w_rx = RX_IN;
`endif

  assign w_start_edge = r_prev & ~w_rx;
  assign w_wrap       = (r_edge_cnt == C_WRAP);
  assign w_decide     = (r_edge_cnt == C_DECIDE);
  assign w_last_bit   = (r_bit_cnt == C_LASTB);
  // Third vote is the live sample taken in the decision cycle itself.
  assign w_majority   = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
  assign w_par_exp    = r_par_typ ? ~(^r_shift) : (^r_shift);

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_state_next = S_START;
        end
      end
      S_START: begin
        // A start bit that votes high was a glitch: drop it silently.
        if (w_decide && w_majority) begin
          w_state_next = S_IDLE;
        end else if (w_wrap) begin
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_wrap && w_last_bit) begin
          w_state_next = r_par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_wrap) begin
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        // Leave at the decision point so the tail of the stop bit can be
        // followed immediately by the next start edge.
        if (w_decide) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath, counters and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_prev     <= 1'b1;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_bad  <= 1'b0;
      r_stop_bit <= 1'b1;
      r_res_pend <= 1'b0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      r_prev     <= w_rx;
      r_res_pend <= 1'b0;
      Data_Valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;

      // Result is published the cycle after the stop-bit decision.
      if (r_res_pend) begin
        if (r_stop_bit && !r_par_bad) begin
          Data_Valid <= 1'b1;
          P_DATA     <= r_shift;
        end else begin
          par_err <= r_par_bad;
          stp_err <= ~r_stop_bit;
        end
      end

      if (r_state == S_IDLE) begin
        r_bit_cnt <= '0;
        if (w_start_edge) begin
          // The edge cycle is count 0, so the next cycle is count 1.
          r_edge_cnt <= CW'(1);
          r_par_en   <= PAR_EN;
          r_par_typ  <= PAR_TYP;
          r_par_bad  <= 1'b0;
        end else begin
          r_edge_cnt <= '0;
        end
      end else begin
        r_edge_cnt <= w_wrap ? '0 : (r_edge_cnt + CW'(1));

        if (r_edge_cnt == C_SAMP0) begin
          r_s0 <= w_rx;
        end
        if (r_edge_cnt == C_SAMP1) begin
          r_s1 <= w_rx;
        end

        if (w_decide) begin
          case (r_state)
            S_DATA:   r_shift    <= {w_majority, r_shift[DATA_WIDTH-1:1]};
            S_PARITY: r_par_bad  <= (w_majority != w_par_exp);
            S_STOP: begin
              r_stop_bit <= w_majority;
              r_res_pend <= 1'b1;
            end
            default: ;
          endcase
        end

        if ((r_state == S_DATA) && w_wrap) begin
          r_bit_cnt <= r_bit_cnt + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_core
//   Self-checking bench for uart_rx_core (OVERSAMPLE=8, DATA_WIDTH=8).
//   Serial lines are built as one level per clock cycle, played into RX_IN,
//   and every output pulse is logged with its cycle index relative to the
//   first cycle of the line (the start-edge cycle). A frame-level model
//   derives the expected flags, data and pulse cycle from the frame content.
//   Honours RX_INPUT_SYNC_EN (expected latencies +2 when defined).
// ---------------------------------------------------------------------------
module tb_uart_rx_core;

  localparam int OS = 8;
  localparam int DW = 8;
`ifdef RX_INPUT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          par_err;
  logic          stp_err;

  uart_rx_core #(.OVERSAMPLE(OS), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .P_DATA(P_DATA), .Data_Valid(Data_Valid), .par_err(par_err), .stp_err(stp_err)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  bit            line_q[$];
  int            dv_q[$];
  logic [DW-1:0] pd_q[$];
  int            pe_q[$];
  int            se_q[$];
  int            rst_idx  = -1;
  int            flip_idx = -1;
  logic [DW+2:0] rst_snap;
  logic [DW-1:0] exp_pdata = '0;

  // ---------------- line construction ----------------
  task automatic add_level(input bit v, input int n);
    for (int k = 0; k < n; k++) line_q.push_back(v);
  endtask

  task automatic add_frame(input logic [DW-1:0] d, input bit pen, input bit pbit, input bit sbit);
    add_level(1'b0, OS);
    for (int b = 0; b < DW; b++) add_level(d[b], OS);
    if (pen) add_level(pbit, OS);
    add_level(sbit, OS);
  endtask

  // Plays line_q into RX_IN and logs every pulse by cycle index.
  task automatic run_line();
    dv_q.delete(); pd_q.delete(); pe_q.delete(); se_q.delete();
    for (int i = 0; i < line_q.size(); i++) begin
      RX_IN = line_q[i];
      if (i == flip_idx) begin
        PAR_EN  = ~PAR_EN;
        PAR_TYP = ~PAR_TYP;
      end
      RST = (i == rst_idx) ? 1'b0 : 1'b1;
      @(posedge CLK); #1;
      if (Data_Valid === 1'b1) begin dv_q.push_back(i); pd_q.push_back(P_DATA); end
      if (par_err === 1'b1) pe_q.push_back(i);
      if (stp_err === 1'b1) se_q.push_back(i);
      if (i == rst_idx) rst_snap = {Data_Valid, par_err, stp_err, P_DATA};
    end
    RST = 1'b1;
    line_q.delete();
    rst_idx  = -1;
    flip_idx = -1;
  endtask

  // Pulse summary: -1 none, -2 more than one, else cycle of the single pulse.
  function automatic int pulse_at(input int q[$]);
    if (q.size() == 0) return -1;
    if (q.size() > 1) return -2;
    return q[0];
  endfunction

  // ---------------- reference model (frame level) ----------------
  task automatic model_frame(input logic [DW-1:0] d, input bit pen, input bit ptyp,
                             input bit pbit, input bit sbit,
                             output int e_dv, output int e_pe, output int e_se);
    bit want_par;
    int lat;
    bit pbad;
    want_par = ptyp ? ~(^d) : (^d);
    pbad     = pen && (pbit != want_par);
    lat      = (1 + DW + (pen ? 1 : 0)) * OS + OS / 2 + 2 + SYNC_LAT;
    e_dv     = (!pbad && sbit) ? lat : -1;
    e_pe     = pbad ? lat : -1;
    e_se     = !sbit ? lat : -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b0; RX_IN = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++; if (P_DATA !== '0) $display("FAIL reset_pdata: got %h want 00", P_DATA); else n_pass++;
    n_checks++; if ({Data_Valid, par_err, stp_err} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {Data_Valid, par_err, stp_err}); else n_pass++;
    RST = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    n_checks++; if ({Data_Valid, par_err, stp_err} !== 3'b000)
      $display("FAIL idle_flags: got %b want 000", {Data_Valid, par_err, stp_err}); else n_pass++;
    $display("reset: P_DATA=%h flags=%b", P_DATA, {Data_Valid, par_err, stp_err});
  endtask

  task automatic test_good_parity();
    int e_dv, e_pe, e_se;
    PAR_EN = 1'b1; PAR_TYP = 1'b0;
    add_frame(8'hA5, 1'b1, 1'b0, 1'b1); add_level(1'b1, 4);
    model_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, e_dv, e_pe, e_se);
    run_line();
    n_checks++; if (pulse_at(dv_q) !== e_dv) $display("FAIL a5_dv_cycle: got %0d want %0d", pulse_at(dv_q), e_dv); else n_pass++;
    n_checks++; if (pd_q.size() != 1 || pd_q[0] !== 8'hA5) $display("FAIL a5_data: got %h want a5", P_DATA); else n_pass++;
    n_checks++; if (pulse_at(pe_q) !== e_pe || pulse_at(se_q) !== e_se)
      $display("FAIL a5_errs: got pe=%0d se=%0d want %0d %0d", pulse_at(pe_q), pulse_at(se_q), e_pe, e_se); else n_pass++;
    exp_pdata = 8'hA5;
    $display("frame a5 even-par: dv@%0d P_DATA=%h", pulse_at(dv_q), P_DATA);
  endtask

  task automatic test_parity_error();
    int e_dv, e_pe, e_se;
    PAR_EN = 1'b1; PAR_TYP = 1'b1;
    add_frame(8'h3C, 1'b1, 1'b0, 1'b1); add_level(1'b1, 4);
    model_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, e_dv, e_pe, e_se);
    run_line();
    n_checks++; if (pulse_at(pe_q) !== e_pe) $display("FAIL 3c_par_err: got %0d want %0d", pulse_at(pe_q), e_pe); else n_pass++;
    n_checks++; if (pulse_at(dv_q) !== e_dv || pulse_at(se_q) !== e_se)
      $display("FAIL 3c_other: got dv=%0d se=%0d want %0d %0d", pulse_at(dv_q), pulse_at(se_q), e_dv, e_se); else n_pass++;
    n_checks++; if (P_DATA !== exp_pdata) $display("FAIL 3c_hold: got %h want %h", P_DATA, exp_pdata); else n_pass++;
    $display("frame 3c odd-par bad: pe@%0d P_DATA=%h", pulse_at(pe_q), P_DATA);
  endtask

  task automatic test_stop_error();
    int e_dv, e_pe, e_se;
    PAR_EN = 1'b0; PAR_TYP = 1'b0;
    add_frame(8'h55, 1'b0, 1'b0, 1'b0);
    add_level(1'b0, 40);          // line stays low: no re-trigger allowed
    add_level(1'b1, 6);
    model_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, e_dv, e_pe, e_se);
    run_line();
    n_checks++; if (pulse_at(se_q) !== e_se) $display("FAIL 55_stp_err: got %0d want %0d", pulse_at(se_q), e_se); else n_pass++;
    n_checks++; if (pulse_at(dv_q) !== e_dv || pulse_at(pe_q) !== e_pe)
      $display("FAIL 55_other: got dv=%0d pe=%0d want %0d %0d", pulse_at(dv_q), pulse_at(pe_q), e_dv, e_pe); else n_pass++;
    n_checks++; if (P_DATA !== exp_pdata) $display("FAIL 55_hold: got %h want %h", P_DATA, exp_pdata); else n_pass++;
    $display("frame 55 stop low: se@%0d P_DATA=%h", pulse_at(se_q), P_DATA);
  endtask

  task automatic test_glitch();
    int e_dv, e_pe, e_se;
    PAR_EN = 1'b0; PAR_TYP = 1'b0;
    add_level(1'b0, 3); add_level(1'b1, 20);
    run_line();
    n_checks++; if (dv_q.size() + pe_q.size() + se_q.size() != 0)
      $display("FAIL glitch_pulses: got %0d pulses want 0", dv_q.size() + pe_q.size() + se_q.size()); else n_pass++;
    add_frame(8'h81, 1'b0, 1'b0, 1'b1); add_level(1'b1, 4);
    model_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, e_dv, e_pe, e_se);
    run_line();
    n_checks++; if (pulse_at(dv_q) !== e_dv || pd_q.size() != 1 || pd_q[0] !== 8'h81)
      $display("FAIL 81_after_glitch: got dv=%0d data=%h want %0d 81", pulse_at(dv_q), P_DATA, e_dv); else n_pass++;
    exp_pdata = 8'h81;
    $display("glitch then frame 81: dv@%0d P_DATA=%h", pulse_at(dv_q), P_DATA);
  endtask

  task automatic test_back_to_back();
    int e_dv, e_pe, e_se;
    PAR_EN = 1'b0; PAR_TYP = 1'b0;
    add_frame(8'h00, 1'b0, 1'b0, 1'b1);
    add_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    add_level(1'b1, 6);
    model_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, e_dv, e_pe, e_se);
    run_line();
    n_checks++; if (dv_q.size() != 2 || dv_q[0] !== e_dv || dv_q[1] !== e_dv + (2 + DW) * OS)
      $display("FAIL b2b_cycles: got n=%0d first=%0d want 2 pulses at %0d,%0d", dv_q.size(), pulse_at(dv_q), e_dv, e_dv + (2 + DW) * OS); else n_pass++;
    n_checks++; if (pd_q.size() != 2 || pd_q[0] !== 8'h00 || pd_q[1] !== 8'hFF)
      $display("FAIL b2b_data: got n=%0d last=%h want 00,ff", pd_q.size(), P_DATA); else n_pass++;
    n_checks++; if (pe_q.size() + se_q.size() != 0) $display("FAIL b2b_errs: got %0d want 0", pe_q.size() + se_q.size()); else n_pass++;
    exp_pdata = 8'hFF;
    $display("back-to-back 00,ff: %0d pulses P_DATA=%h", dv_q.size(), P_DATA);
  endtask

  task automatic test_cfg_midframe();
    int e_dv, e_pe, e_se;
    PAR_EN = 1'b1; PAR_TYP = 1'b0;
    add_frame(8'h96, 1'b1, 1'b0, 1'b1); add_level(1'b1, 4);
    flip_idx = 30;                 // PAR_EN/PAR_TYP flip during data bits
    model_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b1, e_dv, e_pe, e_se);
    run_line();
    n_checks++; if (pulse_at(dv_q) !== e_dv || pulse_at(pe_q) !== e_pe || pulse_at(se_q) !== e_se)
      $display("FAIL cfg_latch: got dv=%0d pe=%0d se=%0d want %0d %0d %0d",
               pulse_at(dv_q), pulse_at(pe_q), pulse_at(se_q), e_dv, e_pe, e_se); else n_pass++;
    exp_pdata = 8'h96;
    $display("frame 96 cfg flipped mid-frame: dv@%0d P_DATA=%h", pulse_at(dv_q), P_DATA);
  endtask

  task automatic test_midframe_reset();
    int e_dv, e_pe, e_se;
    PAR_EN = 1'b0; PAR_TYP = 1'b0;
    add_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    while (line_q.size() > 43) void'(line_q.pop_back());
    add_level(1'b1, 30);
    rst_idx = 42;                  // inside data bit 4
    run_line();
    n_checks++; if (rst_snap !== '0) $display("FAIL rst_mid_outputs: got %h want 0", rst_snap); else n_pass++;
    n_checks++; if (dv_q.size() + pe_q.size() + se_q.size() != 0 || P_DATA !== '0)
      $display("FAIL rst_mid_after: got pulses=%0d P_DATA=%h want 0 00", dv_q.size() + pe_q.size() + se_q.size(), P_DATA); else n_pass++;
    exp_pdata = '0;
    add_frame(8'hC3, 1'b0, 1'b0, 1'b1); add_level(1'b1, 4);
    model_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, e_dv, e_pe, e_se);
    run_line();
    n_checks++; if (pulse_at(dv_q) !== e_dv || pd_q.size() != 1 || pd_q[0] !== 8'hC3 || pe_q.size() + se_q.size() != 0)
      $display("FAIL c3_after_rst: got dv=%0d data=%h want %0d c3", pulse_at(dv_q), P_DATA, e_dv); else n_pass++;
    exp_pdata = 8'hC3;
    $display("mid-frame reset then c3: dv@%0d P_DATA=%h", pulse_at(dv_q), P_DATA);
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    bit pen, ptyp, pbit, sbit;
    int e_dv, e_pe, e_se;
    for (int n = 0; n < 24; n++) begin
      d    = DW'($urandom_range(0, 255));
      pen  = 1'($urandom_range(0, 1));
      ptyp = 1'($urandom_range(0, 1));
      pbit = (ptyp ? ~(^d) : (^d)) ^ ($urandom_range(0, 3) == 0);
      sbit = ($urandom_range(0, 3) != 0);
      PAR_EN = pen; PAR_TYP = ptyp;
      add_frame(d, pen, pbit, sbit);
      add_level(1'b1, $urandom_range(2, 6));
      model_frame(d, pen, ptyp, pbit, sbit, e_dv, e_pe, e_se);
      run_line();
      if (e_dv >= 0) exp_pdata = d;
      n_checks++; if (pulse_at(dv_q) !== e_dv || pulse_at(pe_q) !== e_pe || pulse_at(se_q) !== e_se)
        $display("FAIL rnd%0d_pulses: got dv=%0d pe=%0d se=%0d want %0d %0d %0d", n,
                 pulse_at(dv_q), pulse_at(pe_q), pulse_at(se_q), e_dv, e_pe, e_se); else n_pass++;
      n_checks++; if (P_DATA !== exp_pdata) $display("FAIL rnd%0d_pdata: got %h want %h", n, P_DATA, exp_pdata); else n_pass++;
      $display("rnd %0d: data=%h pen=%0d ptyp=%0d pbit=%0d stop=%0d -> dv@%0d pe@%0d se@%0d P_DATA=%h",
               n, d, pen, ptyp, pbit, sbit, pulse_at(dv_q), pulse_at(pe_q), pulse_at(se_q), P_DATA);
    end
  endtask

  initial begin
    test_reset();
    test_good_parity();
    test_parity_error();
    test_stop_error();
    test_glitch();
    test_back_to_back();
    test_cfg_midframe();
    test_midframe_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
